// File: rtl/blit_seq_pkg.sv
// blit_seq_pkg
//   Shared definitions for the blitter command sequencer: the FSM state
//   encoding, the default geometry (program address width, parameter block
//   length, mode register index) and a small state-classification helper.
package blit_seq_pkg;

  localparam int BLIT_ADDR_W_DEF   = 20;
  localparam int BLIT_NPAR_DEF     = 12;
  localparam int BLIT_MODE_IDX_DEF = 6;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CMDREQ  = 4'd1,
    CMDLD   = 4'd2,
    CHK     = 4'd3,
    PARREQ  = 4'd4,
    PARLD   = 4'd5,
    START   = 4'd6,
    RUNNING = 4'd7,
    STOPPED = 4'd8
  } blit_state_e;

  // States in which a program fetch is outstanding on the bus.
  function automatic logic is_fetch_state(input blit_state_e st);
    return (st == CMDREQ) || (st == PARREQ);
  endfunction

endpackage

// File: rtl/blit_pc.sv
// blit_pc
//   Program counter for the blitter sequencer. Loads a new address or
//   advances by one; the increment wraps modulo 2^ADDR_W.
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset, clears the counter
//   ld_i     : load ld_val_i (wins over inc_i)
//   inc_i    : advance by one
//   ld_val_i : load value
//   pc_o     : current program address
module blit_pc #(
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] ld_val_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld_i) begin
      pc_d = ld_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/blit_seq.sv
// blit_seq
//   Blitter command sequencer. Fetches command and parameter words from
//   program memory, issues the register load strobes for each, starts the
//   datapath and waits for completion or a collision stop.
// Ports
//   CCLK    : clock, rising edge
//   RESET   : asynchronous active-high reset
//   SRESET  : synchronous soft reset (returns to IDLE, keeps ADDR)
//   RUN, PARRD, COLST : command register bits (run, read params, stop on coll.)
//   COLL    : datapath collision
//   RESUME  : leave STOPPED
//   OPDONE  : datapath finished the current operation
//   PCLD, PCIN : program counter load (honoured in IDLE only)
//   BACK    : bus acknowledge, qualified by BREQ
//   BREQ, ADDR : program fetch request and address
//   LDCMDL, LDMODL, PARLDL : active-low register load strobes
//   PARSEL  : parameter index being loaded
//   OPSTART : datapath start pulse
//   STOP    : halted on collision
//   BUSY    : state is not IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for RUN
// CMDREQ  | command word fetch on the bus
// CMDLD   | LDCMDL strobe
// CHK     | decide on the freshly loaded command
// PARREQ  | parameter word fetch on the bus
// PARLD   | PARLDL strobe (plus LDMODL for the mode byte)
// START   | OPSTART pulse
// RUNNING | datapath active, wait for OPDONE or collision
// STOPPED | halted on collision until RESUME
module blit_seq
  import blit_seq_pkg::*;
#(
  parameter int ADDR_W   = BLIT_ADDR_W_DEF,
  parameter int NPAR     = BLIT_NPAR_DEF,
  parameter int MODE_IDX = BLIT_MODE_IDX_DEF
) (
  input  logic              CCLK,
  input  logic              RESET,
  input  logic              SRESET,
  input  logic              RUN,
  input  logic              PARRD,
  input  logic              COLST,
  input  logic              COLL,
  input  logic              RESUME,
  input  logic              OPDONE,
  input  logic              PCLD,
  input  logic [ADDR_W-1:0] PCIN,
  input  logic              BACK,
  output logic              BREQ,
  output logic [ADDR_W-1:0] ADDR,
  output logic              LDCMDL,
  output logic              LDMODL,
  output logic              PARLDL,
  output logic [3:0]        PARSEL,
  output logic              OPSTART,
  output logic              STOP,
  output logic              BUSY
);

  localparam logic [3:0] LAST_IDX = 4'(NPAR - 1);
  localparam logic [3:0] MODE_SEL = 4'(MODE_IDX);

  blit_state_e state_q;
  logic        breq_q;
  logic        ldcmdl_q;
  logic        ldmodl_q;
  logic        parldl_q;
  logic [3:0]  parsel_q;
  logic        opstart_q;
  logic        stop_q;
  logic        busy_q;

  logic        pc_ld;
  logic        pc_inc;
  logic        bus_ack;

  // BACK only counts while a fetch is actually requested.
  assign bus_ack = breq_q & BACK & is_fetch_state(state_q);

  // Soft reset freezes the address: it blocks both load and increment.
  assign pc_ld  = (state_q == IDLE) & PCLD & ~SRESET;
  assign pc_inc = bus_ack & ~SRESET;

  blit_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk_i    (CCLK),
    .rst_i    (RESET),
    .ld_i     (pc_ld),
    .inc_i    (pc_inc),
    .ld_val_i (PCIN),
    .pc_o     (ADDR)
  );

  // All outputs are registered alongside the state so every strobe is
  // glitch-free and lines up with the state it belongs to.
  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      breq_q    <= 1'b0;
      ldcmdl_q  <= 1'b1;
      ldmodl_q  <= 1'b1;
      parldl_q  <= 1'b1;
      parsel_q  <= 4'd0;
      opstart_q <= 1'b0;
      stop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle: default them inactive every cycle.
      ldcmdl_q  <= 1'b1;
      ldmodl_q  <= 1'b1;
      parldl_q  <= 1'b1;
      opstart_q <= 1'b0;

      if (SRESET) begin
        state_q  <= IDLE;
        breq_q   <= 1'b0;
        parsel_q <= 4'd0;
        stop_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            parsel_q <= 4'd0;
            if (RUN) begin
              busy_q <= 1'b1;
              if (PARRD) begin
                state_q <= PARREQ;
                breq_q  <= 1'b1;
              end else begin
                state_q   <= START;
                opstart_q <= 1'b1;
              end
            end
          end

          CMDREQ: begin
            if (bus_ack) begin
              state_q  <= CMDLD;
              breq_q   <= 1'b0;
              ldcmdl_q <= 1'b0;
            end
          end

          CMDLD: begin
            state_q <= CHK;
          end

          CHK: begin
            if (!RUN) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (PARRD) begin
              state_q  <= PARREQ;
              breq_q   <= 1'b1;
              parsel_q <= 4'd0;
            end else begin
              state_q   <= START;
              opstart_q <= 1'b1;
            end
          end

          PARREQ: begin
            if (bus_ack) begin
              state_q  <= PARLD;
              breq_q   <= 1'b0;
              parldl_q <= 1'b0;
              ldmodl_q <= (parsel_q != MODE_SEL);
            end
          end

          PARLD: begin
            parsel_q <= parsel_q + 4'd1;
            if (parsel_q == LAST_IDX) begin
              state_q   <= START;
              opstart_q <= 1'b1;
            end else begin
              state_q <= PARREQ;
              breq_q  <= 1'b1;
            end
          end

          START: begin
            state_q <= RUNNING;
          end

          RUNNING: begin
            // A stop-on-collision outranks a completion in the same cycle.
            if (COLL && COLST) begin
              state_q <= STOPPED;
              stop_q  <= 1'b1;
            end else if (OPDONE) begin
              state_q <= CMDREQ;
              breq_q  <= 1'b1;
            end
          end

          STOPPED: begin
            if (RESUME) begin
              state_q <= RUNNING;
              stop_q  <= 1'b0;
            end
          end

          default: begin
            state_q <= IDLE;
            breq_q  <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign BREQ    = breq_q;
  assign LDCMDL  = ldcmdl_q;
  assign LDMODL  = ldmodl_q;
  assign PARLDL  = parldl_q;
  assign PARSEL  = parsel_q;
  assign OPSTART = opstart_q;
  assign STOP    = stop_q;
  assign BUSY    = busy_q;

endmodule
